// File: rtl/trng_collector_pkg.sv
// rtl/trng_collector_pkg.sv - shared defaults and FSM encodings for the TRNG collector.
// Optional repetition health test is enabled by defining TRNG_HEALTH_EN.
package trng_collector_pkg;

  localparam int TRNG_WORD_WIDTH = 8;
  localparam int TRNG_DROP_W     = 16;
  localparam int TRNG_REP_LIMIT  = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_STALL   = 2'd2
  } state_e;

endpackage

// File: rtl/trng_collector_debias.sv
// rtl/trng_collector_debias.sv - von Neumann extractor, one registered output bit per unequal pair.
// Deasserting enable drops any half-collected pair.
module von_neumann_debias (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic raw_bit,
  input  logic raw_valid,
  output logic db_bit,
  output logic db_valid
);

  logic pair_full_q;
  logic first_q;
  logic db_bit_q;
  logic db_valid_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pair_full_q <= 1'b0;
      first_q     <= 1'b0;
      db_bit_q    <= 1'b0;
      db_valid_q  <= 1'b0;
    end else begin
      db_valid_q <= 1'b0;
      if (!enable) begin
        pair_full_q <= 1'b0;
      end else if (raw_valid) begin
        if (!pair_full_q) begin
          first_q     <= raw_bit;
          pair_full_q <= 1'b1;
        end else begin
          pair_full_q <= 1'b0;
          // 01 -> 0, 10 -> 1: the emitted bit equals the first bit of the pair
          if (first_q != raw_bit) begin
            db_valid_q <= 1'b1;
            db_bit_q   <= first_q;
          end
        end
      end
    end
  end

  assign db_bit   = db_bit_q;
  assign db_valid = db_valid_q;

endmodule

// File: rtl/trng_collector.sv
// rtl/trng_collector.sv - debiases raw RO bits, packs them into words, hands words out via valid/ready.
// Define TRNG_HEALTH_EN to build the repetition-count health test.
module trng_collector
  import trng_collector_pkg::*;
#(
  parameter int WORD_WIDTH = TRNG_WORD_WIDTH,
  parameter int DROP_W     = TRNG_DROP_W,
  parameter int REP_LIMIT  = TRNG_REP_LIMIT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  raw_bit,
  input  logic                  raw_valid,
  output logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic [DROP_W-1:0]     drop_count,
  output logic                  health_fail
);

  localparam int CNT_W = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1;

  logic                  db_bit;
  logic                  db_valid;
  logic                  collect_en;
  logic                  xfer;
  logic                  out_free;
  logic [WORD_WIDTH-1:0] shifted;

  state_e                state_q;
  logic [WORD_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      count_q;
  logic [WORD_WIDTH-1:0] word_data_q;
  logic                  word_valid_q;
  logic [DROP_W-1:0]     drop_q;

`ifdef TRNG_HEALTH_EN
  localparam int RUN_W = $clog2(REP_LIMIT + 1);

  logic [RUN_W-1:0] run_q;
  logic             last_q;
  logic             health_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_q    <= '0;
      last_q   <= 1'b0;
      health_q <= 1'b0;
    end else begin
      if (enable && raw_valid) begin
        last_q <= raw_bit;
        if (run_q != '0 && raw_bit == last_q) begin
          if (run_q != RUN_W'(REP_LIMIT)) run_q <= run_q + 1'b1;
        end else begin
          run_q <= RUN_W'(1);
        end
      end
      if (run_q == RUN_W'(REP_LIMIT)) health_q <= 1'b1;
    end
  end

  assign health_fail = health_q;
`else
  assign health_fail = 1'b0;
`endif

  // A failed health test freezes collection exactly like enable=0
  assign collect_en = enable & ~health_fail;
  assign xfer       = word_valid_q & word_ready;
  assign out_free   = ~word_valid_q | xfer;
  assign shifted    = {shift_q[WORD_WIDTH-2:0], db_bit};

  von_neumann_debias u_debias (
    .clock    (clock),
    .reset    (reset),
    .enable   (collect_en),
    .raw_bit  (raw_bit),
    .raw_valid(raw_valid),
    .db_bit   (db_bit),
    .db_valid (db_valid)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      count_q      <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      if (xfer) word_valid_q <= 1'b0;
      if (!collect_en) begin
        state_q <= ST_IDLE;
        shift_q <= '0;
        count_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_COLLECT;
          ST_COLLECT: begin
            if (db_valid) begin
              if (count_q == CNT_W'(WORD_WIDTH - 1)) begin
                count_q <= '0;
                if (out_free) begin
                  word_data_q  <= shifted;
                  word_valid_q <= 1'b1;
                end else begin
                  shift_q <= shifted;
                  state_q <= ST_STALL;
                end
              end else begin
                shift_q <= shifted;
                count_q <= count_q + 1'b1;
              end
            end
          end
          ST_STALL: begin
            if (db_valid && drop_q != {DROP_W{1'b1}}) drop_q <= drop_q + 1'b1;
            if (xfer) begin
              word_data_q  <= shift_q;
              word_valid_q <= 1'b1;
              shift_q      <= '0;
              count_q      <= '0;
              state_q      <= ST_COLLECT;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign drop_count = drop_q;

endmodule
